// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding unit.
//   SEL_RF       - forwarding select value meaning "read the register file".
//   fsm_state_e  - load-use stall tracker states.
//   sel_w()      - width of one per-operand forwarding select.
package hazard_pkg;

  localparam int SEL_RF = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

  // One code per producer stage plus the register-file code.
  function automatic int sel_w(input int num_stg);
    return $clog2(num_stg + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: bundle between the decode/pipeline control and the
// hazard/forwarding unit.
//   master (pipeline side): drives decode sources, stage destinations, flush;
//                           receives fwd_sel, stall, statistics, hazard_err.
//   slave  (unit side)    : the reverse.
interface hazard_forward_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int CNT_W   = 16
) ();

  localparam int SEL_W = sel_w(NUM_STG);

  logic                       id_valid;
  logic [NUM_SRC*REG_AW-1:0]  id_src;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [NUM_STG*REG_AW-1:0]  stg_rd;
  logic [NUM_STG-1:0]         stg_wr;
  logic [NUM_STG-1:0]         stg_load;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;
  logic [CNT_W-1:0]           fwd_cnt;
  logic                       hazard_err;

  modport master (
    output id_valid, id_src, id_src_used, stg_rd, stg_wr, stg_load, flush,
    input  fwd_sel, stall, stall_cnt, fwd_cnt, hazard_err
  );

  modport slave (
    input  id_valid, id_src, id_src_used, stg_rd, stg_wr, stg_load, flush,
    output fwd_sel, stall, stall_cnt, fwd_cnt, hazard_err
  );

endinterface

// File: rtl/hazard_forward_unit_src_match.sv
// src_match: priority comparator for one decode source operand against
// NUM_STG producer stages.
//   valid, used   - instruction is real and this source is read
//   src           - source register address
//   stg_rd/wr/load- per-stage destination, write-enable, load flag
//   sel           - EX-time select of the youngest matching producer (0 = RF)
//   load_haz      - that winning producer is a load whose data is not ready
module src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_STG  = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = sel_w(NUM_STG)
) (
  input  logic                      valid,
  input  logic                      used,
  input  logic [REG_AW-1:0]         src,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]        stg_wr,
  input  logic [NUM_STG-1:0]        stg_load,
  output logic [SEL_W-1:0]          sel,
  output logic                      load_haz
);

  // Walk from the oldest stage to the youngest so the youngest match is the
  // last one written and therefore wins. A matching non-load younger than a
  // load hides the load, since only the winning producer's readiness matters.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    sel      = SEL_W'(SEL_RF);
    load_haz = 1'b0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (valid && used && stg_wr[k] &&
          (stg_rd[k*REG_AW +: REG_AW] != '0) &&
          (stg_rd[k*REG_AW +: REG_AW] == src)) begin
        sel      = SEL_W'(k + 1);
        load_haz = stg_load[k] && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: registered per-operand forwarding selects for the
// instruction entering EX, combinational load-use stall, saturating stall and
// forward statistics, and a sticky watchdog for over-long stalls.
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - slave side of hazard_forward_unit_if (decode sources, stage
//            destinations, flush in; fwd_sel, stall, counters, hazard_err out)
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_unit_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_STG);
  // Run length only has to reach LOAD_LAT+1; it saturates beyond that.
  localparam int RUN_W = $clog2(LOAD_LAT + 2);

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic [NUM_SRC-1:0]       load_haz;
  logic                     stall;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [CNT_W-1:0]         fwd_cnt_q;
  logic                     hazard_err_q;

  fsm_state_e               state_q, state_d;
  logic [RUN_W-1:0]         run_len_q, run_len_d;
  logic                     err_set;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    src_match #(
      .REG_AW   (REG_AW),
      .NUM_STG  (NUM_STG),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_src_match (
      .valid    (bus.id_valid),
      .used     (bus.id_src_used[i]),
      .src      (bus.id_src[i*REG_AW +: REG_AW]),
      .stg_rd   (bus.stg_rd),
      .stg_wr   (bus.stg_wr),
      .stg_load (bus.stg_load),
      .sel      (sel_raw[i*SEL_W +: SEL_W]),
      .load_haz (load_haz[i])
    );
  end

  // Flush discards the decode instruction, so it cannot cause a stall.
  assign stall = rst_n && !bus.flush && (|load_haz);

  // A bubble, a flushed slot or an empty slot reads the register file.
  assign sel_next = (stall || bus.flush || !bus.id_valid) ? '0 : sel_raw;

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    err_set   = 1'b0;
    if (bus.flush) begin
      state_d   = RUN;
      run_len_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            state_d   = STALL;
            run_len_d = RUN_W'(1);
          end
        end
        STALL: begin
          if (stall) begin
            err_set = (run_len_q >= RUN_W'(LOAD_LAT));
            if (run_len_q != '1) run_len_d = run_len_q + 1'b1;
          end else begin
            state_d   = RUN;
            run_len_d = '0;
          end
        end
        default: begin
          state_d   = RUN;
          run_len_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      run_len_q    <= '0;
      fwd_sel_q    <= '0;
      stall_cnt_q  <= '0;
      fwd_cnt_q    <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      fwd_sel_q    <= sel_next;
      hazard_err_q <= hazard_err_q | err_set;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((|sel_next) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

  assign bus.fwd_sel    = fwd_sel_q;
  assign bus.stall      = stall;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.fwd_cnt    = fwd_cnt_q;
  assign bus.hazard_err = hazard_err_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed cases for forwarding,
// priority, load-use, r0/unused sources, watchdog, flush, saturation and
// reset, followed by a short random run, all checked against a behavioural
// model through a scoreboard queue.
module tb_hazard_forward_unit;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int NUM_STG  = 2;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 3;
  localparam int SEL_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         fwd_cnt;
    logic                     err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(
    .REG_AW (REG_AW), .NUM_SRC (NUM_SRC), .NUM_STG (NUM_STG), .CNT_W (CNT_W)
  ) bus ();

  hazard_forward_unit #(
    .REG_AW (REG_AW), .NUM_SRC (NUM_SRC), .NUM_STG (NUM_STG),
    .LOAD_LAT (LOAD_LAT), .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stimulus variables, packed onto the bus by step().
  logic              rst_v, valid_v, flush_v;
  logic [REG_AW-1:0] src_v [NUM_SRC];
  logic              used_v[NUM_SRC];
  logic [REG_AW-1:0] rd_v  [NUM_STG];
  logic              wr_v  [NUM_STG];
  logic              ld_v  [NUM_STG];

  // Model state.
  logic m_stall_state;
  int   m_run, m_scnt, m_fcnt;
  logic m_err;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic clear_inputs();
    rst_v   = 1'b1;
    valid_v = 1'b1;
    flush_v = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_v[i] = '0; used_v[i] = 1'b0;
    end
    for (int k = 0; k < NUM_STG; k++) begin
      rd_v[k] = '0; wr_v[k] = 1'b0; ld_v[k] = 1'b0;
    end
  endtask

  // Called at a falling edge: drive, check stall, predict, clock, compare.
  task automatic step(input string tag);
    logic                     e_stall;
    logic [NUM_SRC*SEL_W-1:0] e_sel;
    logic                     found;
    exp_t                     e, g;
    bus.id_valid = valid_v;
    bus.flush    = flush_v;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.id_src[i*REG_AW +: REG_AW] = src_v[i];
      bus.id_src_used[i]             = used_v[i];
    end
    for (int k = 0; k < NUM_STG; k++) begin
      bus.stg_rd[k*REG_AW +: REG_AW] = rd_v[k];
      bus.stg_wr[k]                  = wr_v[k];
      bus.stg_load[k]                = ld_v[k];
    end
    rst_n = rst_v;
    #1;

    // Reference: youngest matching producer decides select and readiness.
    e_stall = 1'b0;
    e_sel   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_STG; k++) begin
        if (!found && valid_v && used_v[i] && wr_v[k] && rd_v[k] != 0 &&
            rd_v[k] == src_v[i]) begin
          found = 1'b1;
          e_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (ld_v[k] && k < LOAD_LAT) e_stall = 1'b1;
        end
      end
    end
    e_stall = e_stall && rst_v && !flush_v;
    if (e_stall || flush_v || !valid_v) e_sel = '0;
    check({tag, "/stall"}, 32'(bus.stall), 32'(e_stall));

    if (!rst_v) begin
      m_stall_state = 1'b0; m_run = 0; m_scnt = 0; m_fcnt = 0; m_err = 1'b0;
      e_sel = '0;
    end else begin
      if (e_stall && m_scnt < CNT_MAX) m_scnt++;
      if (e_sel != 0 && m_fcnt < CNT_MAX) m_fcnt++;
      if (flush_v) begin
        m_stall_state = 1'b0; m_run = 0;
      end else if (!m_stall_state) begin
        if (e_stall) begin m_stall_state = 1'b1; m_run = 1; end
      end else if (e_stall) begin
        if (m_run >= LOAD_LAT) m_err = 1'b1;
        m_run++;
      end else begin
        m_stall_state = 1'b0; m_run = 0;
      end
    end
    e.sel = e_sel; e.stall_cnt = CNT_W'(m_scnt);
    e.fwd_cnt = CNT_W'(m_fcnt); e.err = m_err;
    sb.push_back(e);

    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, "/fwd_sel"},    32'(bus.fwd_sel),    32'(g.sel));
    check({tag, "/stall_cnt"},  32'(bus.stall_cnt),  32'(g.stall_cnt));
    check({tag, "/fwd_cnt"},    32'(bus.fwd_cnt),    32'(g.fwd_cnt));
    check({tag, "/hazard_err"}, 32'(bus.hazard_err), 32'(g.err));
    @(negedge clk);
  endtask

  task automatic set_load_use();
    clear_inputs();
    rd_v[0] = 5'd8; wr_v[0] = 1'b1; ld_v[0] = 1'b1;
    src_v[0] = 5'd8; used_v[0] = 1'b1;
  endtask

  initial begin
    m_stall_state = 1'b0; m_run = 0; m_scnt = 0; m_fcnt = 0; m_err = 1'b0;
    clear_inputs();
    @(negedge clk);

    // Reset state.
    rst_v = 1'b0; step("reset0"); step("reset1");
    check("reset/fwd_sel", 32'(bus.fwd_sel), 0);
    check("reset/stall_cnt", 32'(bus.stall_cnt), 0);

    // EX/MEM forward.
    clear_inputs();
    rd_v[0] = 5'd5; wr_v[0] = 1'b1; src_v[0] = 5'd5; used_v[0] = 1'b1;
    step("t1");
    check("t1/sel0_is_1", 32'(bus.fwd_sel[1:0]), 1);
    check("t1/fwd_cnt_is_1", 32'(bus.fwd_cnt), 1);

    // Priority: youngest producer wins; then the older one when younger is idle.
    clear_inputs();
    rd_v[0] = 5'd6; wr_v[0] = 1'b1; rd_v[1] = 5'd6; wr_v[1] = 1'b1;
    src_v[1] = 5'd6; used_v[1] = 1'b1;
    step("t2a");
    check("t2a/sel1_is_1", 32'(bus.fwd_sel[3:2]), 1);
    wr_v[0] = 1'b0;
    step("t2b");
    check("t2b/sel1_is_2", 32'(bus.fwd_sel[3:2]), 2);

    // Load-use, then the load moves one stage down and forwards.
    set_load_use();
    step("t3a");
    check("t3a/stall_is_1", 32'(bus.stall), 1);
    check("t3a/sel_is_0", 32'(bus.fwd_sel), 0);
    check("t3a/stall_cnt_is_1", 32'(bus.stall_cnt), 1);
    clear_inputs();
    rd_v[1] = 5'd8; wr_v[1] = 1'b1; ld_v[1] = 1'b1;
    src_v[0] = 5'd8; used_v[0] = 1'b1;
    step("t3b");
    check("t3b/sel0_is_2", 32'(bus.fwd_sel[1:0]), 2);

    // r0 never forwards; unused source never matches.
    clear_inputs();
    rd_v[0] = 5'd0; wr_v[0] = 1'b1; src_v[0] = 5'd0; used_v[0] = 1'b1;
    step("t4a");
    check("t4a/sel_is_0", 32'(bus.fwd_sel), 0);
    clear_inputs();
    rd_v[0] = 5'd3; wr_v[0] = 1'b1; ld_v[0] = 1'b1; src_v[0] = 5'd3;
    step("t4b");
    check("t4b/stall_is_0", 32'(bus.stall), 0);

    // Watchdog: two consecutive stall edges exceed LOAD_LAT, flag is sticky.
    set_load_use();
    step("t5a");
    check("t5a/err_still_0", 32'(bus.hazard_err), 0);
    step("t5b");
    check("t5b/err_is_1", 32'(bus.hazard_err), 1);
    clear_inputs();
    step("t5c");
    check("t5c/err_sticky", 32'(bus.hazard_err), 1);

    // Flush masks the stall.
    set_load_use();
    flush_v = 1'b1;
    step("t5d");
    check("t5d/flush_stall_0", 32'(bus.stall), 0);
    flush_v = 1'b0;
    step("t5e");

    // Saturation, then reset in the middle of the stall.
    set_load_use();
    for (int n = 0; n < 10; n++) step("t6sat");
    check("t6/stall_cnt_sat", 32'(bus.stall_cnt), CNT_MAX);
    rst_v = 1'b0;
    step("t6rst");
    check("t6rst/stall_cnt_0", 32'(bus.stall_cnt), 0);
    check("t6rst/err_0", 32'(bus.hazard_err), 0);
    rst_v = 1'b1;
    step("t6post");

    // Random mix over a tiny register space for frequent matches.
    for (int n = 0; n < 60; n++) begin
      valid_v = ($urandom_range(7) != 0);
      flush_v = ($urandom_range(7) == 0);
      rst_v   = ($urandom_range(39) != 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        src_v[i]  = REG_AW'($urandom_range(3));
        used_v[i] = 1'($urandom_range(1));
      end
      for (int k = 0; k < NUM_STG; k++) begin
        rd_v[k] = REG_AW'($urandom_range(3));
        wr_v[k] = 1'($urandom_range(1));
        ld_v[k] = 1'($urandom_range(1));
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
